// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding, default loop-filter settings and configuration type
// for the DDR3 PLL lock sequencer.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_ENABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_DISABLE   = 3'd4,
      S_FAIL      = 3'd5
   } pll_state_t;

   localparam logic [5:0] ICP_DEFAULT    = 6'd16;
   localparam logic [2:0] LPFRES_DEFAULT = 3'd2;
   localparam logic [1:0] LPFCAP_DEFAULT = 2'd0;

   // Outputs are gated for this many cycles before the PLL is put back in reset.
   localparam int DISABLE_CYCLES = 2;

   typedef struct packed {
      logic [5:0] icpsel;
      logic [2:0] lpfres;
      logic [1:0] lpfcap;
   } pll_cfg_t;

   localparam pll_cfg_t CFG_DEFAULT = '{
      icpsel: ICP_DEFAULT,
      lpfres: LPFRES_DEFAULT,
      lpfcap: LPFCAP_DEFAULT
   };

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // NOTE: non-blocking assignments keep this a two-stage chain; blocking ones would collapse it to one flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// DDR3 PLL bring-up and supervision: reset, lock qualification with timeout and
// retries, ordered output-clock enable, and re-sequencing on lock loss or reconfiguration.
module pll_lock_sequencer
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES         = 27,
   parameter int LOCK_STABLE_CYCLES = 2700,
   parameter int LOCK_TIMEOUT       = 27000,
   parameter int MAX_RETRY          = 3,
   parameter int ENABLE_GAP         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_update,
   input  logic [5:0] cfg_icpsel,
   input  logic [2:0] cfg_lpfres,
   input  logic [1:0] cfg_lpfcap,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_icpsel,
   output logic [2:0] pll_lpfres,
   output logic [1:0] pll_lpfcap,
   output logic       pll_enclk0,
   output logic       pll_enclk2,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam int CNT_W = $clog2(max_int(max_int(RST_CYCLES, LOCK_STABLE_CYCLES),
                                         max_int(LOCK_TIMEOUT, ENABLE_GAP))) + 1;

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(ENABLE_GAP - 1);
   localparam logic [CNT_W-1:0] DISABLE_LAST = CNT_W'(DISABLE_CYCLES - 1);
   localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

   pll_state_t       r_state;
   pll_state_t       w_state_next;
   logic [CNT_W-1:0] r_timer;
   logic [CNT_W-1:0] r_stable;
   logic [1:0]       r_retry;
   logic [1:0]       w_retry_inc;
   logic [7:0]       r_loss;
   pll_cfg_t         r_shadow;
   pll_cfg_t         r_cfg;
   pll_cfg_t         w_cfg_in;

   logic r_pll_reset, r_enclk0, r_enclk2, r_ready, r_fail;
   logic w_pll_reset, w_enclk0, w_enclk2, w_ready, w_fail;
   logic w_lock_s, w_stable_hit, w_timeout_hit, w_lock_lost, w_reset_entry;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (pll_lock),
      .o_q   (w_lock_s)
   );

   assign w_cfg_in      = '{icpsel: cfg_icpsel, lpfres: cfg_lpfres, lpfcap: cfg_lpfcap};
   assign w_retry_inc   = r_retry + 2'd1;
   assign w_stable_hit  = (r_state == S_WAIT_LOCK) && w_lock_s && (r_stable == STABLE_LAST);
   assign w_timeout_hit = (r_state == S_WAIT_LOCK) && !w_stable_hit && (r_timer == TIMEOUT_LAST);
   assign w_lock_lost   = ((r_state == S_ENABLE) || (r_state == S_RUN)) && !w_lock_s;
   // A cfg_update while already in S_RESET restarts it, so it counts as an entry.
   assign w_reset_entry = (w_state_next == S_RESET) && ((r_state != S_RESET) || cfg_update);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_RESET;
         r_pll_reset <= 1'b1;
         r_enclk0    <= 1'b0;
         r_enclk2    <= 1'b0;
         r_ready     <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_pll_reset <= w_pll_reset;
         r_enclk0    <= w_enclk0;
         r_enclk2    <= w_enclk2;
         r_ready     <= w_ready;
         r_fail      <= w_fail;
      end
   end

   always_comb begin
      // NOTE: default assignment first so every path assigns w_state_next and no latch is inferred.
      w_state_next = r_state;
      if (cfg_update) begin
         w_state_next = r_enclk0 ? S_DISABLE : S_RESET;
      end else begin
         unique case (r_state)
            S_RESET:     if (r_timer == RST_LAST) w_state_next = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
               if (w_stable_hit)       w_state_next = S_ENABLE;
               else if (w_timeout_hit) w_state_next = (w_retry_inc == RETRY_LIMIT) ? S_FAIL : S_RESET;
            end
            S_ENABLE: begin
               if (!w_lock_s)                w_state_next = S_DISABLE;
               else if (r_timer == GAP_LAST) w_state_next = S_RUN;
            end
            S_RUN:       if (!w_lock_s) w_state_next = S_DISABLE;
            S_DISABLE:   if (r_timer == DISABLE_LAST) w_state_next = S_RESET;
            S_FAIL:      w_state_next = S_FAIL;
            default:     w_state_next = S_RESET;
         endcase
      end
   end

   // Decoded from the next state so the registered outputs line up with r_state.
   always_comb begin
      w_pll_reset = (w_state_next == S_RESET) || (w_state_next == S_FAIL);
      w_enclk0    = (w_state_next == S_ENABLE) || (w_state_next == S_RUN);
      w_enclk2    = (w_state_next == S_RUN);
      w_ready     = (w_state_next == S_RUN);
      w_fail      = (w_state_next == S_FAIL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_timer  <= '0;
         r_stable <= '0;
         r_retry  <= '0;
         r_loss   <= '0;
         // NOTE: the shadow config is reset too, so a reset always brings the PLL up on defaults.
         r_shadow <= CFG_DEFAULT;
         r_cfg    <= CFG_DEFAULT;
      end else begin
         if ((w_state_next != r_state) || cfg_update)
            r_timer <= '0;
         else if ((r_state != S_RUN) && (r_state != S_FAIL))
            r_timer <= r_timer + 1'b1;

         if ((r_state == S_WAIT_LOCK) && (w_state_next == S_WAIT_LOCK) && w_lock_s)
            r_stable <= r_stable + 1'b1;
         else
            r_stable <= '0;

         if (cfg_update || ((w_state_next == S_RUN) && (r_state != S_RUN)))
            r_retry <= '0;
         else if (w_timeout_hit)
            r_retry <= w_retry_inc;

         if (w_lock_lost && (r_loss != 8'hFF))
            r_loss <= r_loss + 8'd1;

         if (cfg_update)
            r_shadow <= w_cfg_in;

         if (w_reset_entry)
            r_cfg <= cfg_update ? w_cfg_in : r_shadow;
      end
   end

   assign pll_reset  = r_pll_reset;
   assign pll_icpsel = r_cfg.icpsel;
   assign pll_lpfres = r_cfg.lpfres;
   assign pll_lpfcap = r_cfg.lpfcap;
   assign pll_enclk0 = r_enclk0;
   assign pll_enclk2 = r_enclk2;
   assign ready      = r_ready;
   assign fail       = r_fail;
   assign retry_cnt  = r_retry;
   assign loss_cnt   = r_loss;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: a phase/countdown model checked every
// cycle, plus directed scenarios with hand-computed latencies and values.
module tb_pll_lock_sequencer;

   localparam int RST_C     = 4;
   localparam int STABLE_C  = 8;
   localparam int TIMEOUT_C = 32;
   localparam int RETRY_C   = 2;
   localparam int GAP_C     = 2;

   localparam logic [10:0] CFG_DEF = {6'd16, 3'd2, 2'd0};

   logic       clk        = 1'b0;
   logic       reset      = 1'b1;
   logic       cfg_update = 1'b0;
   logic [5:0] cfg_icpsel = 6'd0;
   logic [2:0] cfg_lpfres = 3'd0;
   logic [1:0] cfg_lpfcap = 2'd0;
   logic       pll_lock   = 1'b0;

   logic       pll_reset;
   logic [5:0] pll_icpsel;
   logic [2:0] pll_lpfres;
   logic [1:0] pll_lpfcap;
   logic       pll_enclk0;
   logic       pll_enclk2;
   logic       ready;
   logic       fail;
   logic [1:0] retry_cnt;
   logic [7:0] loss_cnt;

   pll_lock_sequencer #(
      .RST_CYCLES         (RST_C),
      .LOCK_STABLE_CYCLES (STABLE_C),
      .LOCK_TIMEOUT       (TIMEOUT_C),
      .MAX_RETRY          (RETRY_C),
      .ENABLE_GAP         (GAP_C)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_update (cfg_update),
      .cfg_icpsel (cfg_icpsel),
      .cfg_lpfres (cfg_lpfres),
      .cfg_lpfcap (cfg_lpfcap),
      .pll_lock   (pll_lock),
      .pll_reset  (pll_reset),
      .pll_icpsel (pll_icpsel),
      .pll_lpfres (pll_lpfres),
      .pll_lpfcap (pll_lpfcap),
      .pll_enclk0 (pll_enclk0),
      .pll_enclk2 (pll_enclk2),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase plus remaining-cycle countdowns.
   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_EN   = 2;
   localparam int P_RUN  = 3;
   localparam int P_DIS  = 4;
   localparam int P_FAIL = 5;

   int          m_phase, m_left, m_streak, m_waited, m_retry, m_loss;
   logic [10:0] m_cfg, m_shadow;
   bit          m_valid = 1'b0;
   bit          lock_q[$];

   task m_go_reset(input logic [10:0] c);
      m_phase = P_RST;
      m_left  = RST_C;
      m_cfg   = c;
   endtask

   task m_go_disable();
      m_phase = P_DIS;
      m_left  = 2;
   endtask

   always @(posedge clk) begin : model
      bit ls;
      if (reset) begin
         m_valid  = 1'b1;
         m_go_reset(CFG_DEF);
         m_shadow = CFG_DEF;
         m_retry  = 0;
         m_loss   = 0;
         m_streak = 0;
         m_waited = 0;
         lock_q   = {};
         lock_q.push_back(1'b0);
         lock_q.push_back(1'b0);
      end else if (m_valid) begin
         ls = lock_q.pop_front();
         lock_q.push_back(pll_lock);
         if ((m_phase == P_EN || m_phase == P_RUN) && !ls && m_loss < 255) m_loss++;
         if (cfg_update) begin
            m_shadow = {cfg_icpsel, cfg_lpfres, cfg_lpfcap};
            m_retry  = 0;
            if (m_phase == P_EN || m_phase == P_RUN) m_go_disable();
            else m_go_reset(m_shadow);
         end else begin
            case (m_phase)
               P_RST: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_phase  = P_WAIT;
                     m_streak = 0;
                     m_waited = 0;
                  end
               end
               P_WAIT: begin
                  m_streak = ls ? m_streak + 1 : 0;
                  m_waited++;
                  if (m_streak == STABLE_C) begin
                     m_phase = P_EN;
                     m_left  = GAP_C;
                  end else if (m_waited == TIMEOUT_C) begin
                     m_retry++;
                     if (m_retry == RETRY_C) m_phase = P_FAIL;
                     else m_go_reset(m_shadow);
                  end
               end
               P_EN: begin
                  if (!ls) m_go_disable();
                  else begin
                     m_left--;
                     if (m_left == 0) begin
                        m_phase = P_RUN;
                        m_retry = 0;
                     end
                  end
               end
               P_RUN: if (!ls) m_go_disable();
               P_DIS: begin
                  m_left--;
                  if (m_left == 0) m_go_reset(m_shadow);
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("cyc_pll_reset", 32'(pll_reset),  32'(m_phase == P_RST || m_phase == P_FAIL));
         check("cyc_enclk0",    32'(pll_enclk0), 32'(m_phase == P_EN || m_phase == P_RUN));
         check("cyc_enclk2",    32'(pll_enclk2), 32'(m_phase == P_RUN));
         check("cyc_ready",     32'(ready),      32'(m_phase == P_RUN));
         check("cyc_fail",      32'(fail),       32'(m_phase == P_FAIL));
         check("cyc_retry_cnt", 32'(retry_cnt),  32'(m_retry));
         check("cyc_loss_cnt",  32'(loss_cnt),   32'(m_loss));
         check("cyc_cfg",       32'({pll_icpsel, pll_lpfres, pll_lpfcap}), 32'(m_cfg));
      end
   end

   localparam int SIG_RST  = 0;
   localparam int SIG_EN0  = 1;
   localparam int SIG_EN2  = 2;
   localparam int SIG_RDY  = 3;
   localparam int SIG_FAIL = 4;

   function automatic logic sig(input int sel);
      case (sel)
         SIG_RST:  return pll_reset;
         SIG_EN0:  return pll_enclk0;
         SIG_EN2:  return pll_enclk2;
         SIG_RDY:  return ready;
         SIG_FAIL: return fail;
         default:  return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input string name, input int sel, input logic val,
                             input int limit, output int n);
      n = 0;
      while (sig(sel) !== val && n < limit) begin
         tick();
         n++;
      end
      check({name, "_in_time"}, 32'(sig(sel) === val), 32'd1);
   endtask

   task automatic run_len(input int sel, input logic val, input int limit, output int n);
      n = 0;
      while (sig(sel) === val && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_cfg(input logic [5:0] icp, input logic [2:0] res, input logic [1:0] cap);
      cfg_icpsel = icp;
      cfg_lpfres = res;
      cfg_lpfcap = cap;
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick(); tick(); tick();

      // Reset values
      check("rst_pll_reset", 32'(pll_reset),  32'd1);
      check("rst_enclk0",    32'(pll_enclk0), 32'd0);
      check("rst_ready",     32'(ready),      32'd0);
      check("rst_cfg",       32'({pll_icpsel, pll_lpfres, pll_lpfcap}), 32'(CFG_DEF));

      // Clean lock
      reset = 1'b0;
      run_len(SIG_RST, 1'b1, 20, n);
      check("clean_reset_len", 32'(n), 32'd4);
      repeat (10) tick();
      pll_lock = 1'b1;
      wait_until("clean_enclk0", SIG_EN0, 1'b1, 40, n);
      check("clean_enclk0_latency", 32'(n), 32'd10);
      wait_until("clean_enclk2", SIG_EN2, 1'b1, 10, n);
      check("clean_enclk_gap", 32'(n), 32'd2);
      check("clean_ready", 32'(ready),     32'd1);
      check("clean_retry", 32'(retry_cnt), 32'd0);
      repeat (5) tick();

      // Lock loss in RUN
      pll_lock = 1'b0;
      wait_until("loss_enclk0_fall", SIG_EN0, 1'b0, 10, n);
      check("loss_enclk0_latency", 32'(n), 32'd3);
      pll_lock = 1'b1;
      check("loss_enclk2", 32'(pll_enclk2), 32'd0);
      wait_until("loss_reset_rise", SIG_RST, 1'b1, 10, n);
      check("loss_reset_latency", 32'(n), 32'd2);
      check("loss_cnt_one", 32'(loss_cnt), 32'd1);
      wait_until("loss_relock", SIG_RDY, 1'b1, 60, n);

      // Reconfigure from RUN; new values appear only as pll_reset rises
      repeat (3) tick();
      pulse_cfg(6'd40, 3'd5, 2'd1);
      cfg_icpsel = 6'd63;
      cfg_lpfres = 3'd7;
      cfg_lpfcap = 2'd3;
      check("recfg_enclk0_fall", 32'(pll_enclk0), 32'd0);
      check("recfg_old_icp",     32'(pll_icpsel), 32'd16);
      tick();
      check("recfg_still_running", 32'(pll_reset), 32'd0);
      check("recfg_old_lpfres",    32'(pll_lpfres), 32'd2);
      tick();
      check("recfg_reset_rise", 32'(pll_reset),  32'd1);
      check("recfg_new_icp",    32'(pll_icpsel), 32'd40);
      check("recfg_new_lpfres", 32'(pll_lpfres), 32'd5);
      check("recfg_new_lpfcap", 32'(pll_lpfcap), 32'd1);
      wait_until("recfg_relock", SIG_RDY, 1'b1, 60, n);

      // Retries exhausted
      pll_lock = 1'b0;
      wait_until("retry_first_reset", SIG_RST, 1'b1, 20, n);
      check("retry_loss_to_reset", 32'(n), 32'd5);
      run_len(SIG_RST, 1'b1, 20, n);
      check("retry1_reset_len", 32'(n), 32'd4);
      run_len(SIG_RST, 1'b0, 100, n);
      check("retry1_wait_len", 32'(n), 32'd32);
      check("retry1_cnt", 32'(retry_cnt), 32'd1);
      run_len(SIG_RST, 1'b1, 20, n);
      check("retry2_reset_len", 32'(n), 32'd4);
      run_len(SIG_RST, 1'b0, 100, n);
      check("retry2_wait_len", 32'(n), 32'd32);
      check("fail_flag",  32'(fail),       32'd1);
      check("fail_retry", 32'(retry_cnt),  32'd2);
      check("fail_reset", 32'(pll_reset),  32'd1);
      check("fail_en0",   32'(pll_enclk0), 32'd0);
      check("fail_loss",  32'(loss_cnt),   32'd2);
      check("fail_icp",   32'(pll_icpsel), 32'd40);
      repeat (5) tick();
      check("fail_sticky", 32'(fail), 32'd1);

      // Recovery from FAIL with back-to-back cfg_update; last one wins
      pulse_cfg(6'd9, 3'd3, 2'd2);
      check("recov_fail_low", 32'(fail),      32'd0);
      check("recov_retry",    32'(retry_cnt), 32'd0);
      check("recov_reset",    32'(pll_reset), 32'd1);
      pulse_cfg(6'd7, 3'd1, 2'd3);
      check("recov_icp", 32'(pll_icpsel), 32'd7);
      check("recov_res", 32'(pll_lpfres), 32'd1);
      check("recov_cap", 32'(pll_lpfcap), 32'd3);

      // Glitchy lock: 5 high, 1 low, then steady
      wait_until("glitch_wait_lock", SIG_RST, 1'b0, 20, n);
      repeat (2) tick();
      pll_lock = 1'b1;
      repeat (5) tick();
      pll_lock = 1'b0;
      tick();
      pll_lock = 1'b1;
      wait_until("glitch_enclk0", SIG_EN0, 1'b1, 40, n);
      check("glitch_enclk0_latency", 32'(n), 32'd10);
      check("glitch_enclk2_low", 32'(pll_enclk2), 32'd0);

      // Reset asserted during S_ENABLE
      reset = 1'b1;
      tick();
      check("midrst_reset",  32'(pll_reset),  32'd1);
      check("midrst_en0",    32'(pll_enclk0), 32'd0);
      check("midrst_en2",    32'(pll_enclk2), 32'd0);
      check("midrst_ready",  32'(ready),      32'd0);
      check("midrst_fail",   32'(fail),       32'd0);
      check("midrst_retry",  32'(retry_cnt),  32'd0);
      check("midrst_loss",   32'(loss_cnt),   32'd0);
      check("midrst_cfg",    32'({pll_icpsel, pll_lpfres, pll_lpfcap}), 32'(CFG_DEF));
      reset = 1'b0;
      wait_until("final_ready", SIG_RDY, 1'b1, 60, n);
      check("final_cfg", 32'({pll_icpsel, pll_lpfres, pll_lpfcap}), 32'(CFG_DEF));
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
